// File: rtl/fifo_pkg.sv
// Shared types for the FIFO: encoding of the accepted-request combination per cycle.
package fifo_pkg;

    // Bit order matches {push accepted, pop accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with first-word fall-through output and occupancy-decoded flags.
// Any DEPTH >= 2 is supported; pointers wrap explicitly rather than by overflow.
module fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             nearly_full_o,
    output logic             nearly_empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] NFULL_CNT = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;
    op_e              op;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : PW'(p + 1'b1);
    endfunction

    // Flags come only from the registered count, so no input reaches them combinationally.
    assign full_o         = (count == FULL_CNT);
    assign empty_o        = (count == '0);
    assign nearly_full_o  = (count == NFULL_CNT);
    assign nearly_empty_o = (count == ONE_CNT);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        op = op_e'({do_push, do_pop});
    end

    assign data_o = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    wr_ptr <= next_ptr(wr_ptr);
                    count  <= count + 1'b1;
                end
                OP_POP: begin
                    rd_ptr <= next_ptr(rd_ptr);
                    count  <= count - 1'b1;
                end
                OP_BOTH: begin
                    wr_ptr <= next_ptr(wr_ptr);
                    rd_ptr <= next_ptr(rd_ptr);
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; writes are still blocked while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i && do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo at DEPTH=4, WIDTH=8.
module tb_fifo;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       nfull;
    logic       nempty;

    int tests;
    int fails;

    fifo #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .push_i        (push),
        .pop_i         (pop),
        .data_i        (din),
        .data_o        (dout),
        .full_o        (full),
        .empty_o       (empty),
        .nearly_full_o (nfull),
        .nearly_empty_o(nempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks all four flags and the head word.
    task automatic check_state(input string tag, input logic e, input logic f,
                               input logic nf, input logic ne, input logic [7:0] d);
        check_bit({tag, ".empty"}, empty, e);
        check_bit({tag, ".full"}, full, f);
        check_bit({tag, ".nfull"}, nfull, nf);
        check_bit({tag, ".nempty"}, nempty, ne);
        check_byte({tag, ".data"}, dout, d);
    endtask

    task automatic step(input logic p, input logic q, input logic [7:0] d);
        push = p;
        pop  = q;
        din  = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = 8'h00;

        // Reset held 5 cycles with a push request that reset must override.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hEE);
        check_state("in_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        check_state("after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Fill
        step(1'b1, 1'b0, 8'h11);
        check_state("fill1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        check_state("fill2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h33);
        check_state("fill3", 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h44);
        check_state("fill4", 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);

        // Overflow ignored
        step(1'b1, 1'b0, 8'h55);
        check_state("overflow", 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);

        // Drain
        step(1'b0, 1'b1, 8'h00);
        check_state("drain1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b1, 8'h00);
        check_state("drain2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h33);
        step(1'b0, 1'b1, 8'h00);
        check_state("drain3", 1'b0, 1'b0, 1'b0, 1'b1, 8'h44);
        step(1'b0, 1'b1, 8'h00);
        check_state("drain4", 1'b1, 1'b0, 1'b0, 0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        check_state("underflow", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Empty with both requests: push only, no bypass on the same cycle
        push = 1'b1;
        pop  = 1'b1;
        din  = 8'hA0;
        #1;
        check_byte("no_bypass", dout, 8'h00);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_state("empty_both", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0);
        step(1'b1, 1'b0, 8'hA1);
        check_state("hold2", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0);

        // Concurrent push/pop across pointer wrap; queue is [A0,A1] before the loop
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'hB0 + 8'(i));
            check_state($sformatf("conc%0d", i), 1'b0, 1'b0, 1'b0, 1'b0,
                        (i == 0) ? 8'hA1 : 8'hB0 + 8'(i - 1));
        end

        // Queue is [B8,B9]; fill to full, then both requests -> pop only
        step(1'b1, 1'b0, 8'hC0);
        check_state("refill3", 1'b0, 1'b0, 1'b1, 1'b0, 8'hB8);
        step(1'b1, 1'b0, 8'hC1);
        check_state("refill4", 1'b0, 1'b1, 1'b0, 1'b0, 8'hB8);
        step(1'b1, 1'b1, 8'hD0);
        check_state("full_both", 1'b0, 1'b0, 1'b1, 1'b0, 8'hB9);

        // Mid-operation reset with 3 held and a concurrent push request
        rst = 1'b0;
        step(1'b1, 1'b1, 8'hDD);
        rst = 1'b1;
        check_state("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'hE7);
        check_state("post_reset_push", 1'b0, 1'b0, 1'b0, 1'b1, 8'hE7);
        step(1'b0, 1'b1, 8'h00);
        check_state("post_reset_pop", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
